snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
Parametrised snake movement and rendering engine for the 160x120 VGA adapter path. It holds a multi-segment snake body in an on-chip ring buffer and takes one direction-controlled step per `tick`. Each step checks for wall and self collision, then erases the tail cell and draws the new head cell as BLOCK x BLOCK pixel plots. The x/y/colour/plot outputs drive the vga_adapter write port directly. Direction pulses come from the keyboard tracker in pulse mode.

Parameters:
- BLOCK, 4: cell edge in pixels; must be a power of two, 1..8.
- GRID_W, 40: grid width in cells; GRID_W*BLOCK ≤ 2^X_W.
- GRID_H, 30: grid height in cells; GRID_H*BLOCK ≤ 2^Y_W.
- MAX_LEN, 32: ring buffer depth, i.e. maximum segments; power of two.
- X_W, 8: pixel x width.
- Y_W, 7: pixel y width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- tick  in  1  one-cycle move request.
- left, right, up, down  in  1 each  one-cycle direction pulses.
- grow  in  1  one-cycle grow request.
- colour  in  3  snake colour, sampled at S_DRAW entry.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- c_out  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high in every state except S_IDLE and S_OVER.
- game_over  out  1  sticky collision flag.
- overrun  out  1  sticky flag: a tick arrived while busy.
- length  out  clog2(MAX_LEN)+1  current segment count.

Behaviour:
- Reset (resetn=0 at a clk edge, from any state, including mid-plot):
  - length=1; the single segment (head) is at cell (GRID_W/2, GRID_H/2).
  - dir=RIGHT; grow_pending=0; game_over=0; overrun=0; plot=0.
  - Next state is S_DRAW, which paints the initial head.
- States: S_IDLE, S_CALC, S_SCAN, S_ERASE, S_DRAW, S_OVER.
- S_IDLE: on tick, go to S_CALC. Otherwise stay.
- S_CALC (1 cycle): apply pending_dir to dir, then compute new_head = head ± 1 in x or y.
  - If the step would leave the grid (x<0, x≥GRID_W, y<0, y≥GRID_H), go to S_OVER.
  - Otherwise go to S_SCAN.
- S_SCAN (exactly `length` cycles): compare new_head against one buffer entry per cycle, from tail to head.
  - The tail entry is skipped when grow_pending=0, because it vacates this step.
  - Any match sets a hit flag; after the last compare, hit goes to S_OVER.
  - No hit: push new_head at the head pointer. Then:
    - grow_pending=1 and length<MAX_LEN: length+1, clear grow_pending, go to S_DRAW (no erase).
    - grow_pending=1 and length==MAX_LEN: the grow is discarded and cleared; proceed as a normal move.
    - Normal move: go to S_ERASE.
- S_ERASE (BLOCK² cycles): plot=1, c_out=0. Pixel = old tail cell*BLOCK + {row, col} counter, row-major, col fastest. The tail pointer advances at exit.
- S_DRAW (BLOCK² cycles): plot=1, c_out=colour register; pixels of the head cell in the same order. Exit to S_IDLE.
- S_OVER: plot=0, game_over=1, busy=0. Held until reset; tick, grow and direction pulses are ignored.
- Step latency, from tick to return to S_IDLE:
  - Normal move: 1 (CALC) + length + 2*BLOCK² cycles.
  - Growing move: 1 + length + BLOCK² cycles.
- Direction pulses are accepted in any state except S_OVER and update pending_dir.
  - Simultaneous pulses: priority left > right > up > down.
  - A pulse opposite to dir (the direction of the last move) is ignored.
- A grow pulse sets grow_pending in any state except S_OVER. Multiple grows before a step coalesce into one.
- A tick while busy is dropped and sets overrun.
- Buffer pointers wrap modulo MAX_LEN.
- Outputs x/y/c_out hold their last value when plot=0.

Test Plan:
- Release reset with BLOCK=4 → 16 plot cycles covering x 80..83, y 60..63, c_out=colour → busy=0, length=1.
- Pulse tick (dir RIGHT) → 1 CALC + 1 SCAN cycle, then 16 plots at x 80..83 / y 60..63 with c_out=0, then 16 plots at x 84..87 / y 60..63 with the colour.
- Pulse left while dir=RIGHT, then tick → pulse rejected; head moves to cell (22,15).
- Pulse grow, then tick → no erase phase, 16 draw plots only, length=2; the following tick includes the erase phase again.
- Steer up until the head reaches y=0, then tick → S_OVER, game_over=1, zero plots; later ticks are ignored.
- Grow to length 5, then steer up, left, down → head enters its own body, game_over=1.
- Tick during an erase phase → overrun=1; plot count for that step unchanged.
- Assert reset mid-draw → plot drops the next cycle; initial head redrawn, length=1.

Source files
------------

// File: rtl/snake_engine.sv
// Snake movement and rendering engine: ring-buffered body, one step per tick, with tail erase
// and head draw emitted as BLOCK x BLOCK pixel plots for the VGA adapter write port.
module snake_engine #(
  parameter int unsigned BLOCK   = 4,
  parameter int unsigned GRID_W  = 40,
  parameter int unsigned GRID_H  = 30,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       tick,
  input  logic                       left,
  input  logic                       right,
  input  logic                       up,
  input  logic                       down,
  input  logic                       grow,
  input  logic [2:0]                 colour,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [2:0]                 c_out,
  output logic                       plot,
  output logic                       busy,
  output logic                       game_over,
  output logic                       overrun,
  output logic [$clog2(MAX_LEN):0]   length
);
  localparam int unsigned CX_W  = $clog2(GRID_W + 1);
  localparam int unsigned CY_W  = $clog2(GRID_H + 1);
  localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;
  localparam int unsigned PIX   = BLOCK * BLOCK;
  localparam int unsigned CNT_W = $clog2(PIX) + 1;

  localparam logic [X_W-1:0]   BlkX = X_W'(BLOCK);
  localparam logic [Y_W-1:0]   BlkY = Y_W'(BLOCK);
  localparam logic [CNT_W-1:0] BlkC = CNT_W'(BLOCK);

  typedef enum logic [2:0] {StIdle, StCalc, StScan, StErase, StDraw, StOver} state_e;
  typedef enum logic [1:0] {DirRight, DirLeft, DirUp, DirDown} dir_e;

  state_e            state;
  dir_e              dir, pending_dir, req_dir;
  logic              req_valid, grow_pending, hit, wall, scan_match, scan_last, pix_last;
  logic [CX_W-1:0]   buf_x [MAX_LEN];
  logic [CY_W-1:0]   buf_y [MAX_LEN];
  logic [PTR_W-1:0]  head_ptr, tail_ptr, scan_ptr;
  logic [CX_W-1:0]   new_x, base_x, step_x;
  logic [CY_W-1:0]   new_y, base_y, step_y;
  logic [LEN_W-1:0]  scan_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        colour_q;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;

  assign busy = (state != StIdle) && (state != StOver);

  // Highest-priority pulse wins; a reversal against the last move is dropped outright.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = pending_dir;
    if (left)       req_dir = DirLeft;
    else if (right) req_dir = DirRight;
    else if (up)    req_dir = DirUp;
    else if (down)  req_dir = DirDown;
    else            req_valid = 1'b0;
    if (req_dir == dir_e'(dir ^ 2'b01)) req_valid = 1'b0;
  end

  always_comb begin
    step_x = buf_x[head_ptr];
    step_y = buf_y[head_ptr];
    wall   = 1'b0;
    unique case (pending_dir)
      DirRight: if (step_x == CX_W'(GRID_W - 1)) wall = 1'b1; else step_x = step_x + CX_W'(1);
      DirLeft:  if (step_x == '0) wall = 1'b1; else step_x = step_x - CX_W'(1);
      DirUp:    if (step_y == '0) wall = 1'b1; else step_y = step_y - CY_W'(1);
      DirDown:  if (step_y == CY_W'(GRID_H - 1)) wall = 1'b1; else step_y = step_y + CY_W'(1);
    endcase
  end

  // The tail entry (scan_cnt == 0) vacates on a non-growing step, so it cannot collide.
  always_comb begin
    scan_ptr   = tail_ptr + PTR_W'(scan_cnt);
    scan_match = (buf_x[scan_ptr] == new_x) && (buf_y[scan_ptr] == new_y) &&
                 (grow_pending || (scan_cnt != '0));
    scan_last  = (scan_cnt == length - LEN_W'(1));
    pix_x      = X_W'(base_x) * BlkX + X_W'(cnt % BlkC);
    pix_y      = Y_W'(base_y) * BlkY + Y_W'(cnt / BlkC);
    pix_last   = (cnt == CNT_W'(PIX - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= StDraw;
      dir          <= DirRight;
      pending_dir  <= DirRight;
      grow_pending <= 1'b0;
      game_over    <= 1'b0;
      overrun      <= 1'b0;
      plot         <= 1'b0;
      length       <= LEN_W'(1);
      head_ptr     <= '0;
      tail_ptr     <= '0;
      buf_x[0]     <= CX_W'(GRID_W / 2);
      buf_y[0]     <= CY_W'(GRID_H / 2);
      base_x       <= CX_W'(GRID_W / 2);
      base_y       <= CY_W'(GRID_H / 2);
      new_x        <= CX_W'(GRID_W / 2);
      new_y        <= CY_W'(GRID_H / 2);
      scan_cnt     <= '0;
      hit          <= 1'b0;
      cnt          <= '0;
      colour_q     <= colour;
      x            <= '0;
      y            <= '0;
      c_out        <= '0;
    end else begin
      plot <= 1'b0;
      if (state != StOver) begin
        if (req_valid) pending_dir <= req_dir;
        if (tick && busy) overrun <= 1'b1;
      end
      unique case (state)
        StIdle: if (tick) state <= StCalc;
        StCalc: begin
          dir      <= pending_dir;
          new_x    <= step_x;
          new_y    <= step_y;
          scan_cnt <= '0;
          hit      <= 1'b0;
          if (wall) begin
            state     <= StOver;
            game_over <= 1'b1;
          end else begin
            state <= StScan;
          end
        end
        StScan: begin
          scan_cnt <= scan_cnt + LEN_W'(1);
          hit      <= hit | scan_match;
          if (scan_last) begin
            if (hit || scan_match) begin
              state     <= StOver;
              game_over <= 1'b1;
            end else begin
              head_ptr                      <= head_ptr + PTR_W'(1);
              buf_x[head_ptr + PTR_W'(1)]   <= new_x;
              buf_y[head_ptr + PTR_W'(1)]   <= new_y;
              grow_pending                  <= 1'b0;
              cnt                           <= '0;
              if (grow_pending && (length < LEN_W'(MAX_LEN))) begin
                length   <= length + LEN_W'(1);
                base_x   <= new_x;
                base_y   <= new_y;
                colour_q <= colour;
                state    <= StDraw;
              end else begin
                // Latch the old tail now: at full length the push overwrites its slot.
                base_x <= buf_x[tail_ptr];
                base_y <= buf_y[tail_ptr];
                state  <= StErase;
              end
            end
          end
        end
        StErase, StDraw: begin
          plot  <= 1'b1;
          x     <= pix_x;
          y     <= pix_y;
          c_out <= (state == StErase) ? 3'd0 : colour_q;
          cnt   <= cnt + CNT_W'(1);
          if (pix_last) begin
            cnt <= '0;
            if (state == StErase) begin
              tail_ptr <= tail_ptr + PTR_W'(1);
              base_x   <= new_x;
              base_y   <= new_y;
              colour_q <= colour;
              state    <= StDraw;
            end else begin
              state <= StIdle;
            end
          end
        end
        StOver:  game_over <= 1'b1;
        default: state <= StIdle;
      endcase
      if (grow && (state != StOver)) grow_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed scenarios plus random play against a queue-based snake model.
module tb_snake_engine;
  localparam int B  = 4;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int ML = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0, tick = 1'b0, left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic grow = 1'b0;
  logic [2:0] colour = 3'd5;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] c_out;
  logic plot, busy, game_over, overrun;
  logic [5:0] length;

  snake_engine #(.BLOCK(B), .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .X_W(8), .Y_W(7)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .left(left), .right(right), .up(up), .down(down),
    .grow(grow), .colour(colour), .x(x), .y(y), .c_out(c_out), .plot(plot), .busy(busy),
    .game_over(game_over), .overrun(overrun), .length(length)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t expq[$];
  int sx[$], sy[$];              // index 0 = tail, last = head
  int m_dir, m_pend;             // 0 right, 1 left, 2 up, 3 down
  bit m_grow, m_over, m_overrun;
  int n_cmp = 0, n_fail = 0;
  int nplots = 0, first_x, first_y, last_x, last_y;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (plot === 1'b1) begin
      nplots++;
      last_x = int'(x);
      last_y = int'(y);
      if (nplots == 1) begin first_x = int'(x); first_y = int'(y); end
      n_cmp++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, required no plot", x, y, c_out);
      end else begin
        pix_t p;
        p = expq.pop_front();
        if (int'(x) != p.x || int'(y) != p.y || int'(c_out) != p.c) begin
          n_fail++;
          $display("FAIL plot_pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   x, y, c_out, p.x, p.y, p.c);
        end
      end
    end
  end

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic paint(input int cx, input int cy, input int c);
    for (int r = 0; r < B; r++)
      for (int k = 0; k < B; k++) expq.push_back('{cx * B + k, cy * B + r, c});
  endtask

  task automatic model_reset();
    sx = {GW / 2};
    sy = {GH / 2};
    m_dir = 0; m_pend = 0; m_grow = 0; m_over = 0; m_overrun = 0;
    expq.delete();
    paint(GW / 2, GH / 2, int'(colour));
  endtask

  task automatic model_step(output int lat);
    int nx, ny, len;
    bit hit;
    lat = 0;
    if (m_over) return;
    m_dir = m_pend;
    nx = sx[$] + ((m_dir == 0) ? 1 : (m_dir == 1) ? -1 : 0);
    ny = sy[$] + ((m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0);
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      m_over = 1; lat = 1; return;
    end
    len = sx.size();
    hit = 0;
    for (int i = 0; i < len; i++)
      if (!(i == 0 && !m_grow) && sx[i] == nx && sy[i] == ny) hit = 1;
    lat = 1 + len;
    if (hit) begin m_over = 1; return; end
    sx.push_back(nx);
    sy.push_back(ny);
    if (m_grow && len < ML) begin
      m_grow = 0;
      paint(nx, ny, int'(colour));
      lat += B * B;
    end else begin
      m_grow = 0;
      paint(sx[0], sy[0], 0);
      void'(sx.pop_front());
      void'(sy.pop_front());
      paint(nx, ny, int'(colour));
      lat += 2 * B * B;
    end
  endtask

  // One-cycle pulses on the direction and grow inputs, mirrored into the model.
  task automatic drive(input bit l, input bit r, input bit u, input bit d, input bit g);
    int p;
    left = l; right = r; up = u; down = d; grow = g;
    if (!m_over) begin
      p = l ? 1 : r ? 0 : u ? 2 : d ? 3 : -1;
      if (p >= 0 && p != opposite(m_dir)) m_pend = p;
      if (g) m_grow = 1;
    end
    @(negedge clk);
    left = 0; right = 0; up = 0; down = 0; grow = 0;
  endtask

  task automatic do_step(input int inject);
    int exp_lat, n;
    model_step(exp_lat);
    if (inject >= 1 && inject <= exp_lat) m_overrun = 1;
    tick = 1;
    @(negedge clk);
    tick = 0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick = (n == inject);
      @(negedge clk);
    end
    tick = 0;
    check("step_latency", n, exp_lat);
    repeat (2) @(negedge clk);
    check("length", int'(length), sx.size());
    check("game_over", int'(game_over), int'(m_over));
    check("overrun", int'(overrun), int'(m_overrun));
    check("plots_pending", expq.size(), 0);
  endtask

  task automatic do_reset(input bit check_drop);
    int n;
    resetn = 0;
    @(posedge clk);
    #1;
    model_reset();
    nplots = 0;
    @(negedge clk);
    if (check_drop) check("plot_drop_on_reset", int'(plot), 0);
    resetn = 1;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_plot_count", nplots, B * B);
    check("reset_first_x", first_x, 80);
    check("reset_first_y", first_y, 60);
    check("reset_last_x", last_x, 83);
    check("reset_last_y", last_y, 63);
    check("reset_length", int'(length), 1);
    check("reset_game_over", int'(game_over), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_pending", expq.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int bits;
    @(negedge clk);
    @(negedge clk);
    do_reset(0);

    // Plain step right, then a rejected reversal.
    do_step(0);
    check("step1_last_x", last_x, 87);
    check("step1_last_y", last_y, 63);
    drive(1, 0, 0, 0, 0);
    do_step(0);
    check("model_head_x", sx[$], 22);
    check("reject_last_x", last_x, 91);

    // Growing step skips the erase; the next one erases again.
    drive(0, 0, 0, 0, 1);
    do_step(0);
    check("grow_length", int'(length), 2);
    do_step(0);

    // Tick landing in the erase phase.
    do_step(5);
    check("overrun_flag", int'(overrun), 1);

    // Run up into the top wall.
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) do_step(0);
    check("model_head_y", sy[$], 0);
    do_step(0);
    check("wall_game_over", int'(game_over), 1);
    do_step(0);
    drive(0, 0, 0, 1, 1);
    do_step(0);

    // Self collision at length 5.
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      do_step(0);
    end
    check("len5", int'(length), 5);
    drive(0, 0, 1, 0, 0); do_step(0);
    drive(1, 0, 0, 0, 0); do_step(0);
    drive(0, 0, 0, 1, 0); do_step(0);
    check("self_game_over", int'(game_over), 1);

    // Reset in the middle of a draw phase.
    do_reset(0);
    begin
      int lat;
      model_step(lat);
      tick = 1;
      @(negedge clk);
      tick = 0;
      repeat (22) @(negedge clk);
      check("middraw_plot_active", int'(plot), 1);
      do_reset(1);
    end

    // Random play.
    for (int it = 0; it < 250; it++) begin
      if (m_over) begin
        do_step(0);
        do_reset(0);
        continue;
      end
      colour = 3'($urandom_range(1, 7));
      @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        bits = $urandom;
        drive(bits[0], bits[1], bits[2], bits[3], ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 5) == 0) drive(0, 0, 0, 0, 1);
      end
      do_step(($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
